// File: rtl/dmem_mmio.sv
// dmem_mmio: byte-addressable data RAM with per-lane strobes, an MMIO window (LED register and cycle counter) and out-of-range error reporting.
// Latency: rsp_valid is first sampled high RD_LATENCY clocks after the accept edge. Writes and the read data snapshot both happen on the accept edge.
// Backpressure: one request in flight. req_ready is low from accept until the response is taken, and the response holds while rsp_ready is low.
//
// Ports:
//   clk, rst_n                               clock and synchronous active-low reset
//   req_valid/req_ready                      request handshake
//   req_addr/req_wrdata/req_wrstb            word address, write data, lane strobes (0 = read)
//   rsp_valid/rsp_ready                      response handshake
//   rsp_rddata/rsp_err                       read data (0 for writes and errors), decode error
//   leds                                     LED register contents
module dmem_mmio #(
    parameter int          DEPTH_BYTES = 1024,
    parameter int          RD_LATENCY  = 1,
    parameter int          LED_W       = 4,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wrdata,
    input  logic [3:0]       req_wrstb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rddata,
    output logic             rsp_err,
    output logic [LED_W-1:0] leds
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  lat_cnt, lat_cnt_nxt;
    logic [31:0] cyc_cnt;

    // Storage is zero at time zero only; reset deliberately leaves it alone.
    logic [31:0] mem [WORDS] = '{default: '0};

    logic          accept;
    logic          in_ram;
    logic          in_mmio;
    logic [1:0]    mmio_off;
    logic [AW-3:0] widx;
    logic [31:0]   ram_rd;
    logic [31:0]   ram_wr;
    logic [31:0]   led_ext;
    logic [31:0]   led_wr;
    logic [31:0]   rd_val;
    logic          unused_addr;

    assign unused_addr = ^req_addr[1:0];

    // A request presented in the same cycle as reset is dropped, not committed.
    assign accept   = req_valid && req_ready && rst_n;
    assign in_ram   = req_addr < 32'(DEPTH_BYTES);
    // Compare the upper bits so a window at the very top of the address map cannot overflow.
    assign in_mmio  = req_addr[31:4] == MMIO_BASE[31:4];
    assign mmio_off = req_addr[3:2];
    assign widx     = req_addr[AW-1:2];
    assign ram_rd   = mem[widx];
    assign led_ext  = 32'(leds);

    // Lane merges for the RAM word and the LED register. LED lanes above LED_W fall off in the truncation.
    always_comb begin
        ram_wr = ram_rd;
        led_wr = led_ext;
        for (int i = 0; i < 4; i++) begin
            if (req_wrstb[i]) begin
                ram_wr[8*i +: 8] = req_wrdata[8*i +: 8];
                led_wr[8*i +: 8] = req_wrdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (req_wrstb == 4'b0000) begin
            if (in_ram) begin
                rd_val = ram_rd;
            end else if (in_mmio) begin
                case (mmio_off)
                    2'd0:    rd_val = led_ext;
                    2'd1:    rd_val = cyc_cnt;
                    default: rd_val = '0;
                endcase
            end
        end
    end

    // Control FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (RD_LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt   = WAIT;
                        lat_cnt_nxt = 3'(RD_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                lat_cnt_nxt = lat_cnt - 3'd1;
                if (lat_cnt == 3'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM write port has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (accept && in_ram && (req_wrstb != 4'b0000)) begin
            mem[widx] <= ram_wr;
        end
    end

    // Response registers, LED register and free-running counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_rddata <= '0;
            rsp_err    <= 1'b0;
            leds       <= '0;
            cyc_cnt    <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (accept) begin
                rsp_rddata <= rd_val;
                rsp_err    <= !(in_ram || in_mmio);
                if (in_mmio && (mmio_off == 2'd0) && (req_wrstb != 4'b0000)) begin
                    leds <= led_wr[LED_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed checks of two dmem_mmio instances, one with read latency 1 and one with read latency 4.
// Latency: not applicable.
// Backpressure: rsp_ready is driven per test.
module tb_dmem_mmio;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wrdata [2];
    logic [3:0]  req_wrstb  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rddata [2];
    logic        rsp_err    [2];
    logic [3:0]  leds       [2];

    int nvec = 0;
    int nbad = 0;
    int cyc  = 0;

    dmem_mmio #(.DEPTH_BYTES(1024), .RD_LATENCY(1), .LED_W(4), .MMIO_BASE(MB)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_wrdata(req_wrdata[0]), .req_wrstb(req_wrstb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rddata(rsp_rddata[0]),
        .rsp_err(rsp_err[0]), .leds(leds[0])
    );

    dmem_mmio #(.DEPTH_BYTES(1024), .RD_LATENCY(4), .LED_W(4), .MMIO_BASE(MB)) u_lat4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_wrdata(req_wrdata[1]), .req_wrstb(req_wrstb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rddata(rsp_rddata[1]),
        .rsp_err(rsp_err[1]), .leds(leds[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction: waits for req_ready, optionally aligns the accept to
    // bench cycle at_cyc, then returns the first response seen and how many
    // clocks after the accept edge it appeared.
    task automatic txn(input int d, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] stb, input int at_cyc,
                       output logic [31:0] rd, output logic err, output int acc, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (at_cyc > 0) begin
            while (cyc < at_cyc - 1) @(negedge clk);
        end
        req_valid[d]  = 1'b1;
        req_addr[d]   = addr;
        req_wrdata[d] = wd;
        req_wrstb[d]  = stb;
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid[d] && lat < 20);
        if (!rsp_valid[d]) begin
            nvec++; nbad++;
            $display("FAIL rsp_timeout dut%0d addr=%h: no rsp_valid within %0d cycles", d, addr, lat);
        end
        rd  = rsp_rddata[d];
        err = rsp_err[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            nvec++; if (req_ready[d] !== 1'b1) begin nbad++; $display("FAIL reset_req_ready dut%0d got %b want 1", d, req_ready[d]); end
            nvec++; if (rsp_valid[d] !== 1'b0) begin nbad++; $display("FAIL reset_rsp_valid dut%0d got %b want 0", d, rsp_valid[d]); end
            nvec++; if (rsp_rddata[d] !== 32'h0) begin nbad++; $display("FAIL reset_rddata dut%0d got %h want 0", d, rsp_rddata[d]); end
            nvec++; if (rsp_err[d] !== 1'b0) begin nbad++; $display("FAIL reset_err dut%0d got %b want 0", d, rsp_err[d]); end
            nvec++; if (leds[d] !== 4'h0) begin nbad++; $display("FAIL reset_leds dut%0d got %h want 0", d, leds[d]); end
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic err; int acc, lat;
        txn(0, 32'h010, 32'hA1B2C3D4, 4'b1111, 0, rd, err, acc, lat);
        nvec++; if (rd !== 32'h0) begin nbad++; $display("FAIL wr_rddata got %h want 0", rd); end
        nvec++; if (lat !== 1) begin nbad++; $display("FAIL wr_latency got %0d want 1", lat); end
        txn(0, 32'h010, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (rd !== 32'hA1B2C3D4) begin nbad++; $display("FAIL rd_word got %h want a1b2c3d4", rd); end
        nvec++; if (err !== 1'b0) begin nbad++; $display("FAIL rd_word_err got %b want 0", err); end
        nvec++; if (lat !== 1) begin nbad++; $display("FAIL rd_latency got %0d want 1", lat); end
        // Last word of RAM, and the first byte past it
        txn(0, 32'h3FC, 32'hCAFEF00D, 4'b1111, 0, rd, err, acc, lat);
        txn(0, 32'h3FC, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (rd !== 32'hCAFEF00D) begin nbad++; $display("FAIL rd_last_word got %h want cafef00d", rd); end
        nvec++; if (err !== 1'b0) begin nbad++; $display("FAIL rd_last_word_err got %b want 0", err); end
        txn(0, 32'h400, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (err !== 1'b1) begin nbad++; $display("FAIL rd_past_end_err got %b want 1", err); end
        nvec++; if (rd !== 32'h0) begin nbad++; $display("FAIL rd_past_end_data got %h want 0", rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic err; int acc, lat;
        txn(0, 32'h020, 32'h00000000, 4'b1111, 0, rd, err, acc, lat);
        txn(0, 32'h020, 32'h11223344, 4'b0101, 0, rd, err, acc, lat);
        txn(0, 32'h020, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (rd !== 32'h00220044) begin nbad++; $display("FAIL lanes_0101 got %h want 00220044", rd); end
        txn(0, 32'h020, 32'hFFFFFFFF, 4'b1010, 0, rd, err, acc, lat);
        txn(0, 32'h020, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (rd !== 32'hFF22FF44) begin nbad++; $display("FAIL lanes_1010 got %h want ff22ff44", rd); end
        // Low address bits are ignored: 0x023 reads the same word
        txn(0, 32'h023, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (rd !== 32'hFF22FF44) begin nbad++; $display("FAIL lanes_unaligned got %h want ff22ff44", rd); end
    endtask

    task automatic test_mmio();
        logic [31:0] rd, r1, r2, r3; logic err; int acc, a1, a2, a3, lat;
        txn(0, MB, 32'h0000000F, 4'b0001, 0, rd, err, acc, lat);
        nvec++; if (leds[0] !== 4'hF) begin nbad++; $display("FAIL led_write got %h want f", leds[0]); end
        // Lane 1 maps to LED bits 15:8, which a 4-bit register does not have
        txn(0, MB, 32'h00000500, 4'b0010, 0, rd, err, acc, lat);
        nvec++; if (leds[0] !== 4'hF) begin nbad++; $display("FAIL led_lane1 got %h want f", leds[0]); end
        txn(0, MB, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (rd !== 32'h0000000F) begin nbad++; $display("FAIL led_read got %h want 0000000f", rd); end
        txn(0, MB + 32'h4, 32'h0, 4'b0000, 0, r1, err, a1, lat);
        txn(0, MB + 32'h4, 32'h0, 4'b0000, a1 + 10, r2, err, a2, lat);
        nvec++; if (r2 - r1 !== 32'd10) begin nbad++; $display("FAIL counter_delta got %0d want 10", r2 - r1); end
        txn(0, MB + 32'h4, 32'h0, 4'b1111, 0, rd, err, acc, lat);
        txn(0, MB + 32'h4, 32'h0, 4'b0000, 0, r3, err, a3, lat);
        nvec++; if (r3 - r2 !== 32'(a3 - a2)) begin nbad++; $display("FAIL counter_write_ignored got %0d want %0d", r3 - r2, a3 - a2); end
        txn(0, MB + 32'h8, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (rd !== 32'h0 || err !== 1'b0) begin nbad++; $display("FAIL mmio_reserved got %h/%b want 0/0", rd, err); end
        txn(0, MB + 32'h10, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (err !== 1'b1) begin nbad++; $display("FAIL mmio_past_end_err got %b want 1", err); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic err; int acc, lat;
        rsp_ready[0] = 1'b0;
        txn(0, 32'h0000_8000, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (err !== 1'b1) begin nbad++; $display("FAIL oor_err got %b want 1", err); end
        nvec++; if (rd !== 32'h0) begin nbad++; $display("FAIL oor_rddata got %h want 0", rd); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nvec++;
            if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b1 || rsp_rddata[0] !== 32'h0 || req_ready[0] !== 1'b0) begin
                nbad++;
                $display("FAIL stall_hold cycle %0d got v=%b e=%b d=%h rdy=%b want 1 1 0 0",
                         i, rsp_valid[0], rsp_err[0], rsp_rddata[0], req_ready[0]);
            end
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        nvec++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin nbad++; $display("FAIL stall_release got v=%b rdy=%b want 0 1", rsp_valid[0], req_ready[0]); end
    endtask

    task automatic test_latency4();
        logic [31:0] rd; logic err; int acc, lat;
        int accs [4]; int rsps [4]; int na, nr, n;
        txn(1, 32'h010, 32'h12345678, 4'b1111, 0, rd, err, acc, lat);
        nvec++; if (lat !== 4) begin nbad++; $display("FAIL l4_wr_latency got %0d want 4", lat); end
        txn(1, 32'h010, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (lat !== 4) begin nbad++; $display("FAIL l4_rd_latency got %0d want 4", lat); end
        nvec++; if (rd !== 32'h12345678) begin nbad++; $display("FAIL l4_rd_data got %h want 12345678", rd); end
        // Back to back with req_valid held high
        @(negedge clk);
        na = 0; nr = 0;
        req_valid[1] = 1'b1; req_addr[1] = 32'h010; req_wrstb[1] = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            if (req_ready[1] && na < 4) begin accs[na] = cyc + 1; na++; end
            if (rsp_valid[1] && nr < 4) begin rsps[nr] = cyc; nr++; end
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        n = 0;
        while (!req_ready[1] && n < 20) begin @(negedge clk); n++; end
        nvec++;
        if (na < 3 || nr < 2) begin
            nbad++; $display("FAIL b2b_count got %0d accepts %0d responses want >=3 >=2", na, nr);
        end else begin
            if (accs[1] - accs[0] !== 5 || accs[2] - accs[1] !== 5) begin
                nbad++; $display("FAIL b2b_spacing got %0d,%0d want 5,5", accs[1] - accs[0], accs[2] - accs[1]);
            end
            nvec++;
            if (rsps[0] !== accs[0] + 3 || rsps[1] !== accs[1] + 3) begin
                nbad++; $display("FAIL b2b_rsp_timing got %0d,%0d want %0d,%0d", rsps[0], rsps[1], accs[0] + 3, accs[1] + 3);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic err; int acc, lat, n;
        txn(1, MB, 32'h00000003, 4'b0001, 0, rd, err, acc, lat);
        nvec++; if (leds[1] !== 4'h3) begin nbad++; $display("FAIL l4_led_write got %h want 3", leds[1]); end
        n = 0;
        @(negedge clk);
        while (!req_ready[1] && n < 20) begin @(negedge clk); n++; end
        req_valid[1] = 1'b1; req_addr[1] = 32'h004; req_wrdata[1] = 32'h5A5A1234; req_wrstb[1] = 4'b1111;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        nvec++; if (req_ready[1] !== 1'b0 || rsp_valid[1] !== 1'b0) begin nbad++; $display("FAIL midop_in_wait got rdy=%b v=%b want 0 0", req_ready[1], rsp_valid[1]); end
        rst_n = 1'b0;
        @(negedge clk);
        nvec++; if (rsp_valid[1] !== 1'b0) begin nbad++; $display("FAIL midop_rsp_valid got %b want 0", rsp_valid[1]); end
        nvec++; if (leds[1] !== 4'h0) begin nbad++; $display("FAIL midop_leds got %h want 0", leds[1]); end
        nvec++; if (req_ready[1] !== 1'b1) begin nbad++; $display("FAIL midop_req_ready got %b want 1", req_ready[1]); end
        rst_n = 1'b1;
        txn(1, 32'h004, 32'h0, 4'b0000, 0, rd, err, acc, lat);
        nvec++; if (rd !== 32'h5A5A1234) begin nbad++; $display("FAIL midop_ram_kept got %h want 5a5a1234", rd); end
        nvec++; if (err !== 1'b0 || lat !== 4) begin nbad++; $display("FAIL midop_read got err=%b lat=%0d want 0 4", err, lat); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wrdata[d] = '0;
            req_wrstb[d]  = '0;
            rsp_ready[d]  = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_mmio();
        test_backpressure();
        test_latency4();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Next-generation data memory for the MINAv2 core: parametrised byte-addressable RAM with per-lane write strobes.
- Adds a valid/ready request/response handshake with configurable read latency, an MMIO window (LED register and free-running cycle counter) and out-of-range error reporting.
- Sits between the core's load/store unit and on-chip storage/board LEDs; exactly one request is outstanding at a time.

Parameters:
- DEPTH_BYTES, 1024, RAM size in bytes; power of two, multiple of 4, 16..65536.
- RD_LATENCY, 1, cycles from request accept to rsp_valid; legal 1..4.
- LED_W, 4, width of LED output register; 1..32.
- MMIO_BASE, 32'hFFFF_0000, base of MMIO window; 16-byte aligned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  32  byte address; bits [1:0] ignored (word access).
- req_wrdata  in  32  write data; lane n = bits [8n+7:8n].
- req_wrstb  in  4  per-lane write enable; 4'b0000 = read.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rddata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  address outside RAM and MMIO window.
- leds  out  LED_W  LED register contents.

Behaviour:
- Reset: rst_n sampled on posedge clk, active low, synchronous.
  - Outputs after reset: req_ready=1, rsp_valid=0, rsp_rddata=0, rsp_err=0, leds=0, cycle counter=0, FSM=IDLE.
  - RAM contents are NOT cleared by reset; RAM is initialised to 0 at time zero only.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Accept on req_valid&&req_ready at a posedge.
    - RD_LATENCY==1: go to RESP.
    - RD_LATENCY>1: go to WAIT with latency counter = RD_LATENCY-1.
  - WAIT: req_ready=0. Decrement the counter each cycle; go to RESP when it reaches 1→0.
  - RESP: rsp_valid=1 and req_ready=0. On rsp_ready, go to IDLE on the next edge.
    - rsp_rddata and rsp_err hold stable while rsp_valid && !rsp_ready.
- Latency: rsp_valid rises exactly RD_LATENCY cycles after the accept edge. With rsp_ready tied high, throughput is one request per RD_LATENCY+1 cycles.
- Address decode, using the captured request:
  - RAM: req_addr < DEPTH_BYTES, word index = req_addr[log2(DEPTH_BYTES)-1:2].
  - MMIO: MMIO_BASE <= req_addr < MMIO_BASE+16.
    - +0: LED register, R/W.
    - +4: cycle counter, read-only.
    - +8 and +C: read 0, writes ignored, no error.
  - Anything else: rsp_err=1, rsp_rddata=0, no state change.
- Writes:
  - Committed on the accept edge; each lane n is written only if req_wrstb[n].
  - LED register: lane 0 and lane 1 strobes update bits [min(LED_W,16)-1:0] from req_wrdata correspondingly. Higher lanes apply if LED_W > 16.
  - Writes to the counter are ignored. rsp_rddata=0 for all writes.
- Reads:
  - Little-endian: rsp_rddata[7:0]=byte offset 0, [15:8]=offset 1, [23:16]=offset 2, [31:24]=offset 3.
  - Data is captured at the accept edge, so it reflects all prior completed writes.
  - Cycle counter: 32-bit, +1 every cycle while out of reset, wraps 32'hFFFF_FFFF→0. A read returns the pre-increment value at the accept edge.
- Mixed-strobe masks (e.g. 4'b0101) are legal: only the strobed lanes are written.
- Reset mid-operation: the in-flight request is discarded and rsp_valid=0 the cycle after the reset edge. A write already committed stays in RAM; the LED register is cleared by reset.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- leds is driven directly from the LED register: it updates the cycle after the write is accepted.

Test Plan:
1. RD_LATENCY=1: write 0xA1B2C3D4 strb 4'b1111 to 0x010, then read 0x010 → rsp_rddata=0xA1B2C3D4, rsp_err=0, rsp_valid exactly 1 cycle after accept.
2. Byte lanes: write 0x11223344 strb 4'b0101 to 0x020 over 0x00000000, read back → 0x00220044. Repeat with strb 4'b1010 and data 0xFFFFFFFF → 0xFF22FF44.
3. MMIO: write 0x0000000F to MMIO_BASE → leds=4'hF next cycle. Read MMIO_BASE+4 twice, issued 10 cycles apart → difference equals 10. Write to MMIO_BASE+4 → counter unaffected.
4. Error and backpressure: read 0x0000_8000 with DEPTH_BYTES=1024 → rsp_err=1, rsp_rddata=0. Hold rsp_ready=0 for 5 cycles → response stable and req_ready=0 throughout.
5. RD_LATENCY=4: read with rsp_ready=1 → rsp_valid on cycle 4 after accept; back-to-back requests are accepted every 5 cycles.
6. Reset mid-op: assert rst_n=0 in WAIT after a write to 0x004 → rsp_valid=0, leds=0, req_ready=1 after reset; a subsequent read of 0x004 returns the written data.
